lsq_nb: RTL and testbench

//  Parametrised non-blocking load/store queue between dispatch/issue and the dcache.
//  - Holds up to LSQ_SIZE memory ops in program order.
//  - Allows up to MAX_INFLIGHT outstanding load misses, matched back by dcache tag.
//  - Forwards retired-or-pending store data to younger loads; broadcasts load results on the CDB.

---
 rtl/lsq_nb_if.sv | 65 ++++++
 rtl/lsq_nb.sv | 212 +++++++++++++++++++++
 tb/tb_lsq_nb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lsq_nb_if.sv
// Packet types and the bundled dispatch / CDB / dcache port of the non-blocking LSQ.
package lsq_nb_pkg;
    localparam int XLEN = 32;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    typedef struct packed {
        logic        valid;
        logic        rd_mem;
        logic        wr_mem;
        logic [4:0]  rob_tag;
        logic [31:0] store_data;
        logic [4:0]  store_data_tag;
        logic        store_data_valid;
    } LSQ_PACKET;

    typedef struct packed {
        logic            valid;
        logic [4:0]      tag;
        logic [XLEN-1:0] addr;
    } priv_addr_packet;

    typedef struct packed {
        logic        valid;
        logic [4:0]  tag;
        logic [31:0] value;
    } CDB_PACKET;
endpackage

interface lsq_nb_if #(parameter int LSQ_SIZE_W = 3) ();
    lsq_nb_pkg::LSQ_PACKET       lsq_packet;
    lsq_nb_pkg::priv_addr_packet priv_addr_in;
    lsq_nb_pkg::CDB_PACKET       cdb_in;
    logic                        mem_valid;
    logic [4:0]                  mem_tag;
    logic                        cdb_busy;
    logic [63:0]                 dcache_data_out;
    logic [3:0]                  dcache_tag;
    logic [3:0]                  dcache_response;
    logic                        dcache_hit;
    lsq_nb_pkg::CDB_PACKET       cdb_out;
    logic [1:0]                  dcache_command;
    logic [lsq_nb_pkg::XLEN-1:0] dcache_addr;
    logic [63:0]                 dcache_data;
    logic                        store_ready;
    logic [4:0]                  store_ready_tag;
    logic                        lsq_free;
    logic [3:0]                  inflight_count;
    logic [LSQ_SIZE_W-1:0]       head_ptr;
    logic [LSQ_SIZE_W-1:0]       tail_ptr;

    modport master (
        output lsq_packet, priv_addr_in, cdb_in, mem_valid, mem_tag, cdb_busy,
               dcache_data_out, dcache_tag, dcache_response, dcache_hit,
        input  cdb_out, dcache_command, dcache_addr, dcache_data, store_ready,
               store_ready_tag, lsq_free, inflight_count, head_ptr, tail_ptr
    );
    modport slave (
        input  lsq_packet, priv_addr_in, cdb_in, mem_valid, mem_tag, cdb_busy,
               dcache_data_out, dcache_tag, dcache_response, dcache_hit,
        output cdb_out, dcache_command, dcache_addr, dcache_data, store_ready,
               store_ready_tag, lsq_free, inflight_count, head_ptr, tail_ptr
    );
endinterface

// File: rtl/lsq_nb.sv
// Non-blocking load/store queue: program-ordered entries, store-to-load forwarding,
// tagged outstanding load misses and in-order-of-age CDB broadcast of load results.
module lsq_nb import lsq_nb_pkg::*; #(
    parameter int LSQ_SIZE     = 8,
    parameter int LSQ_SIZE_W   = 3,
    parameter int MAX_INFLIGHT = 4,
    parameter int FORWARD      = 1
) (
    input  logic    clk,
    input  logic    reset,
    lsq_nb_if.slave lsq_if
);
    typedef logic [LSQ_SIZE_W-1:0] idx_t;
    typedef logic [LSQ_SIZE_W:0]   ptr_t;

    typedef struct packed {
        logic            valid;
        logic            is_st;
        logic            addr_valid;
        logic            data_valid;
        logic            retired;
        logic            issued;
        logic            done;
        logic            bcast;
        logic [4:0]      rob_tag;
        logic [4:0]      sd_tag;
        logic [3:0]      mem_id;
        logic [XLEN-1:0] addr;
        logic [63:0]     data;
    } entry_t;

    entry_t [LSQ_SIZE-1:0] ent_q, ent_d;
    ptr_t                  head_q, head_d, tail_q, tail_d;
    logic [3:0]            infl_q, infl_d;
    logic                  free_q, free_d;

    idx_t hidx, tidx, ld_idx, m_idx, cdb_idx;
    ptr_t ld_age;
    logic ld_found, st_addr_ok, match, cdb_found;
    logic fwd, ld_req, st_req, accept, st_acc, ld_acc, cdb_fire, deq, alloc, resp_hit;

    assign hidx = head_q[LSQ_SIZE_W-1:0];
    assign tidx = tail_q[LSQ_SIZE_W-1:0];

    // Walk the queue oldest-first: pick the candidate load, its youngest older
    // matching store, and the oldest finished load awaiting broadcast.
    always_comb begin
        idx_t idx;
        idx        = '0;
        ld_found   = 1'b0;
        ld_idx     = '0;
        ld_age     = '0;
        st_addr_ok = 1'b1;
        match      = 1'b0;
        m_idx      = '0;
        cdb_found  = 1'b0;
        cdb_idx    = '0;
        for (int k = 0; k < LSQ_SIZE; k++) begin
            idx = hidx + idx_t'(k);
            if (ent_q[idx].valid && !ld_found) begin
                if (!ent_q[idx].is_st && ent_q[idx].addr_valid && !ent_q[idx].issued && !ent_q[idx].done) begin
                    ld_found = 1'b1;
                    ld_idx   = idx;
                    ld_age   = ptr_t'(k);
                end else if (ent_q[idx].is_st && !ent_q[idx].addr_valid) begin
                    st_addr_ok = 1'b0;
                end
            end
            if (ent_q[idx].valid && !cdb_found && !ent_q[idx].is_st && ent_q[idx].done && !ent_q[idx].bcast) begin
                cdb_found = 1'b1;
                cdb_idx   = idx;
            end
        end
        for (int k = 0; k < LSQ_SIZE; k++) begin
            idx = hidx + idx_t'(k);
            if (ld_found && ptr_t'(k) < ld_age && ent_q[idx].is_st &&
                ent_q[idx].addr[XLEN-1:2] == ent_q[ld_idx].addr[XLEN-1:2]) begin
                match = 1'b1;
                m_idx = idx;
            end
        end
    end

    assign st_req   = ent_q[hidx].valid && ent_q[hidx].is_st && ent_q[hidx].retired &&
                      ent_q[hidx].addr_valid && ent_q[hidx].data_valid;
    assign fwd      = ld_found && st_addr_ok && match && (FORWARD != 0) && ent_q[m_idx].data_valid;
    assign ld_req   = ld_found && st_addr_ok && !match && (infl_q < 4'(MAX_INFLIGHT));
    assign accept   = lsq_if.dcache_tag != 4'd0;
    assign st_acc   = st_req && accept;
    assign ld_acc   = !st_req && ld_req && accept;
    assign cdb_fire = cdb_found && !lsq_if.cdb_busy;
    assign deq      = st_acc || (ent_q[hidx].valid && !ent_q[hidx].is_st &&
                      (ent_q[hidx].bcast || (cdb_fire && cdb_idx == hidx)));
    assign alloc    = lsq_if.lsq_packet.valid && free_q &&
                      (lsq_if.lsq_packet.rd_mem || lsq_if.lsq_packet.wr_mem);

    always_comb begin
        entry_t e;
        e        = '0;
        resp_hit = 1'b0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            e = ent_q[i];
            if (e.valid) begin
                if (lsq_if.priv_addr_in.valid && lsq_if.priv_addr_in.tag == e.rob_tag && !e.addr_valid) begin
                    e.addr       = lsq_if.priv_addr_in.addr;
                    e.addr_valid = 1'b1;
                end
                if (e.is_st && lsq_if.cdb_in.valid && lsq_if.cdb_in.tag == e.sd_tag && !e.data_valid) begin
                    e.data       = {32'd0, lsq_if.cdb_in.value};
                    e.data_valid = 1'b1;
                end
                if (e.is_st && lsq_if.mem_valid && lsq_if.mem_tag == e.rob_tag)
                    e.retired = 1'b1;
                if (!e.is_st && e.issued && !e.done && lsq_if.dcache_response != 4'd0 &&
                    lsq_if.dcache_response == e.mem_id) begin
                    e.done   = 1'b1;
                    e.data   = lsq_if.dcache_data_out;
                    resp_hit = 1'b1;
                end
            end
            // Forwarded word is replicated so either half selected by addr[2] is correct.
            if (fwd && idx_t'(i) == ld_idx) begin
                e.done = 1'b1;
                e.data = {2{ent_q[m_idx].data[31:0]}};
            end
            if (ld_acc && idx_t'(i) == ld_idx) begin
                e.issued = 1'b1;
                if (lsq_if.dcache_hit) begin
                    e.done = 1'b1;
                    e.data = lsq_if.dcache_data_out;
                end else begin
                    e.mem_id = lsq_if.dcache_tag;
                end
            end
            if (cdb_fire && idx_t'(i) == cdb_idx)
                e.bcast = 1'b1;
            if (alloc && idx_t'(i) == tidx) begin
                e         = '0;
                e.valid   = 1'b1;
                e.is_st   = lsq_if.lsq_packet.wr_mem;
                e.rob_tag = lsq_if.lsq_packet.rob_tag;
                e.sd_tag  = lsq_if.lsq_packet.store_data_tag;
                if (lsq_if.priv_addr_in.valid && lsq_if.priv_addr_in.tag == lsq_if.lsq_packet.rob_tag) begin
                    e.addr       = lsq_if.priv_addr_in.addr;
                    e.addr_valid = 1'b1;
                end
                if (lsq_if.lsq_packet.wr_mem && lsq_if.lsq_packet.store_data_valid) begin
                    e.data       = {32'd0, lsq_if.lsq_packet.store_data};
                    e.data_valid = 1'b1;
                end else if (lsq_if.lsq_packet.wr_mem && lsq_if.cdb_in.valid &&
                             lsq_if.cdb_in.tag == lsq_if.lsq_packet.store_data_tag) begin
                    e.data       = {32'd0, lsq_if.cdb_in.value};
                    e.data_valid = 1'b1;
                end
            end
            if (deq && idx_t'(i) == hidx)
                e = '0;
            ent_d[i] = e;
        end
    end

    assign head_d = head_q + ptr_t'(deq);
    assign tail_d = tail_q + ptr_t'(alloc);
    assign infl_d = infl_q + 4'(ld_acc && !lsq_if.dcache_hit) - 4'(resp_hit);
    assign free_d = !((tail_d[LSQ_SIZE_W-1:0] == head_d[LSQ_SIZE_W-1:0]) &&
                      (tail_d[LSQ_SIZE_W] != head_d[LSQ_SIZE_W]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            infl_q <= '0;
            free_q <= 1'b1;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            infl_q <= infl_d;
            free_q <= free_d;
        end
    end

    always_comb begin
        lsq_if.dcache_command = BUS_NONE;
        lsq_if.dcache_addr    = '0;
        lsq_if.dcache_data    = '0;
        if (st_req) begin
            lsq_if.dcache_command = BUS_STORE;
            lsq_if.dcache_addr    = ent_q[hidx].addr;
            lsq_if.dcache_data    = {32'd0, ent_q[hidx].data[31:0]};
        end else if (ld_req) begin
            lsq_if.dcache_command = BUS_LOAD;
            lsq_if.dcache_addr    = ent_q[ld_idx].addr;
        end
        lsq_if.cdb_out = '0;
        if (cdb_found) begin
            lsq_if.cdb_out.valid = 1'b1;
            lsq_if.cdb_out.tag   = ent_q[cdb_idx].rob_tag;
            lsq_if.cdb_out.value = ent_q[cdb_idx].addr[2] ? ent_q[cdb_idx].data[63:32]
                                                          : ent_q[cdb_idx].data[31:0];
        end
    end

    assign lsq_if.store_ready     = ent_q[hidx].valid && ent_q[hidx].is_st && ent_q[hidx].addr_valid &&
                                    ent_q[hidx].data_valid && !ent_q[hidx].retired;
    assign lsq_if.store_ready_tag = lsq_if.store_ready ? ent_q[hidx].rob_tag : 5'd0;
    assign lsq_if.lsq_free        = free_q;
    assign lsq_if.inflight_count  = infl_q;
    assign lsq_if.head_ptr        = hidx;
    assign lsq_if.tail_ptr        = tidx;
endmodule

// File: tb/tb_lsq_nb.sv
// Directed bench for lsq_nb: hit load, retired store, forwarding, miss tracking,
// full queue with CDB back-pressure, and reset with loads outstanding.
module tb_lsq_nb;
    import lsq_nb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    lsq_nb_if #(.LSQ_SIZE_W(3)) bus ();

    lsq_nb #(.LSQ_SIZE(8), .LSQ_SIZE_W(3), .MAX_INFLIGHT(4), .FORWARD(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .lsq_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.lsq_packet      = '0;
        bus.priv_addr_in    = '0;
        bus.cdb_in          = '0;
        bus.mem_valid       = 1'b0;
        bus.mem_tag         = '0;
        bus.cdb_busy        = 1'b0;
        bus.dcache_data_out = '0;
        bus.dcache_tag      = '0;
        bus.dcache_response = '0;
        bus.dcache_hit      = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic st, input logic [4:0] rob, input logic [31:0] sd,
                         input logic [4:0] sdt, input logic sdv);
        bus.lsq_packet = '{valid: 1'b1, rd_mem: !st, wr_mem: st, rob_tag: rob,
                           store_data: sd, store_data_tag: sdt, store_data_valid: sdv};
    endtask

    task automatic set_addr(input logic [4:0] tag, input logic [31:0] addr);
        bus.priv_addr_in = '{valid: 1'b1, tag: tag, addr: addr};
    endtask

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cdb_valid", bus.cdb_out.valid, 1'b0);
        chk("rst_cmd", bus.dcache_command, BUS_NONE);
        chk("rst_addr", bus.dcache_addr, 32'h0);
        chk("rst_data", bus.dcache_data, 64'h0);
        chk("rst_store_ready", bus.store_ready, 1'b0);
        chk("rst_lsq_free", bus.lsq_free, 1'b1);
        chk("rst_inflight", bus.inflight_count, 4'd0);
        chk("rst_head", bus.head_ptr, 3'd0);
        chk("rst_tail", bus.tail_ptr, 3'd0);
        reset = 1'b0;
        step();

        // T1: load hit
        alloc(1'b0, 5'd5, 32'h0, 5'd0, 1'b0); step();
        set_addr(5'd5, 32'h1000); step();
        chk("t1_cmd", bus.dcache_command, BUS_LOAD);
        chk("t1_addr", bus.dcache_addr, 32'h1000);
        bus.dcache_tag = 4'd1; bus.dcache_hit = 1'b1; bus.dcache_data_out = 64'hDEADBEEF_12340000;
        step();
        chk("t1_cdb_valid", bus.cdb_out.valid, 1'b1);
        chk("t1_cdb_tag", bus.cdb_out.tag, 5'd5);
        chk("t1_cdb_value", bus.cdb_out.value, 32'h12340000);
        chk("t1_inflight", bus.inflight_count, 4'd0);
        step();
        chk("t1_cdb_gone", bus.cdb_out.valid, 1'b0);
        chk("t1_head", bus.head_ptr, 3'd1);
        chk("t1_tail", bus.tail_ptr, 3'd1);

        // T2: store, data from CDB, retired, one nack then accept
        alloc(1'b1, 5'd4, 32'h0, 5'd6, 1'b0); step();
        set_addr(5'd4, 32'h2000);
        bus.cdb_in = '{valid: 1'b1, tag: 5'd6, value: 32'hABCD1234};
        step();
        chk("t2_store_ready", bus.store_ready, 1'b1);
        chk("t2_store_ready_tag", bus.store_ready_tag, 5'd4);
        chk("t2_cmd_unretired", bus.dcache_command, BUS_NONE);
        bus.mem_valid = 1'b1; bus.mem_tag = 5'd4; step();
        chk("t2_cmd", bus.dcache_command, BUS_STORE);
        chk("t2_addr", bus.dcache_addr, 32'h2000);
        chk("t2_data", bus.dcache_data, 64'h00000000_ABCD1234);
        chk("t2_store_ready_retired", bus.store_ready, 1'b0);
        step();
        chk("t2_cmd_after_nack", bus.dcache_command, BUS_STORE);
        chk("t2_head_after_nack", bus.head_ptr, 3'd1);
        bus.dcache_tag = 4'd2; step();
        chk("t2_head", bus.head_ptr, 3'd2);
        chk("t2_cmd_idle", bus.dcache_command, BUS_NONE);
        chk("t2_no_cdb", bus.cdb_out.valid, 1'b0);

        // T3: store-to-load forwarding, upper word
        alloc(1'b1, 5'd4, 32'h55, 5'd0, 1'b1); step();
        alloc(1'b0, 5'd5, 32'h0, 5'd0, 1'b0); set_addr(5'd4, 32'h3004); step();
        set_addr(5'd5, 32'h3004); step();
        chk("t3_no_busload", bus.dcache_command, BUS_NONE);
        step();
        chk("t3_cdb_valid", bus.cdb_out.valid, 1'b1);
        chk("t3_cdb_tag", bus.cdb_out.tag, 5'd5);
        chk("t3_cdb_value", bus.cdb_out.value, 32'h55);
        step();
        bus.mem_valid = 1'b1; bus.mem_tag = 5'd4; step();
        chk("t3_st_cmd", bus.dcache_command, BUS_STORE);
        chk("t3_st_data", bus.dcache_data, 64'h55);
        bus.dcache_tag = 4'd3; step();
        chk("t3_head_mid", bus.head_ptr, 3'd3);
        step();
        chk("t3_head", bus.head_ptr, 3'd4);
        chk("t3_tail", bus.tail_ptr, 3'd4);

        // T4: five loads, four misses, out-of-order responses
        for (int i = 0; i < 5; i++) begin
            alloc(1'b0, 5'(10 + i), 32'h0, 5'd0, 1'b0); step();
        end
        for (int i = 0; i < 5; i++) begin
            set_addr(5'(10 + i), 32'h4000 + 32'(i * 8)); step();
        end
        for (int i = 0; i < 4; i++) begin
            chk("t4_issue_cmd", bus.dcache_command, BUS_LOAD);
            chk("t4_issue_addr", bus.dcache_addr, 32'h4000 + 32'(i * 8));
            bus.dcache_tag = 4'(i + 1); step();
        end
        chk("t4_inflight_max", bus.inflight_count, 4'd4);
        chk("t4_fifth_held", bus.dcache_command, BUS_NONE);
        bus.dcache_response = 4'd3; bus.dcache_data_out = 64'h333; bus.cdb_busy = 1'b1; step();
        chk("t4_inflight_3", bus.inflight_count, 4'd3);
        chk("t4_cdb_first_tag", bus.cdb_out.tag, 5'd12);
        bus.dcache_response = 4'd1; bus.dcache_data_out = 64'h111; bus.cdb_busy = 1'b1; step();
        chk("t4_cdb_oldest_tag", bus.cdb_out.tag, 5'd10);
        chk("t4_cdb_oldest_value", bus.cdb_out.value, 32'h111);
        chk("t4_inflight_2", bus.inflight_count, 4'd2);
        chk("t4_fifth_cmd", bus.dcache_command, BUS_LOAD);
        chk("t4_fifth_addr", bus.dcache_addr, 32'h4020);
        step();
        chk("t4_cdb_next_tag", bus.cdb_out.tag, 5'd12);
        chk("t4_cdb_next_value", bus.cdb_out.value, 32'h333);
        chk("t4_head_after_bcast", bus.head_ptr, 3'd5);
        bus.dcache_tag = 4'd5; bus.dcache_hit = 1'b1; bus.dcache_data_out = 64'h555; step();
        bus.dcache_response = 4'd2; bus.dcache_data_out = 64'h222; step();
        bus.dcache_response = 4'd4; bus.dcache_data_out = 64'h444; step();
        chk("t4_inflight_0", bus.inflight_count, 4'd0);
        repeat (8) step();
        chk("t4_head", bus.head_ptr, 3'd1);
        chk("t4_tail", bus.tail_ptr, 3'd1);
        chk("t4_cdb_idle", bus.cdb_out.valid, 1'b0);

        // T5: full queue, dropped packet, held broadcast
        for (int i = 0; i < 8; i++) begin
            alloc(1'b0, 5'(16 + i), 32'h0, 5'd0, 1'b0); step();
        end
        chk("t5_full", bus.lsq_free, 1'b0);
        alloc(1'b0, 5'd24, 32'h0, 5'd0, 1'b0); step();
        chk("t5_drop_tail", bus.tail_ptr, 3'd1);
        chk("t5_still_full", bus.lsq_free, 1'b0);
        set_addr(5'd16, 32'h5004); step();
        chk("t5_cmd", bus.dcache_command, BUS_LOAD);
        bus.dcache_tag = 4'd1; bus.dcache_hit = 1'b1; bus.dcache_data_out = 64'hCAFEF00D_00000000;
        bus.cdb_busy = 1'b1; step();
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", bus.cdb_out.valid, 1'b1);
            chk("t5_hold_tag", bus.cdb_out.tag, 5'd16);
            chk("t5_hold_value", bus.cdb_out.value, 32'hCAFEF00D);
            chk("t5_hold_head", bus.head_ptr, 3'd1);
            bus.cdb_busy = 1'b1; step();
        end
        chk("t5_release_valid", bus.cdb_out.valid, 1'b1);
        step();
        chk("t5_once", bus.cdb_out.valid, 1'b0);
        chk("t5_head", bus.head_ptr, 3'd2);
        chk("t5_free_again", bus.lsq_free, 1'b1);

        // T6: reset with two misses outstanding, then a stale response
        set_addr(5'd17, 32'h6000); step();
        chk("t6_cmd", bus.dcache_command, BUS_LOAD);
        chk("t6_addr", bus.dcache_addr, 32'h6000);
        bus.dcache_tag = 4'd1; set_addr(5'd18, 32'h6008); step();
        bus.dcache_tag = 4'd2; step();
        chk("t6_inflight_2", bus.inflight_count, 4'd2);
        reset = 1'b1;
        #1;
        chk("t6_async_inflight", bus.inflight_count, 4'd0);
        chk("t6_async_head", bus.head_ptr, 3'd0);
        chk("t6_async_tail", bus.tail_ptr, 3'd0);
        step();
        reset = 1'b0;
        bus.dcache_response = 4'd1; bus.dcache_data_out = 64'h1; step();
        chk("t6_no_cdb", bus.cdb_out.valid, 1'b0);
        chk("t6_inflight", bus.inflight_count, 4'd0);
        chk("t6_head", bus.head_ptr, 3'd0);
        chk("t6_tail", bus.tail_ptr, 3'd0);
        chk("t6_free", bus.lsq_free, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
